// File: rtl/id_stage_if.sv
// IF / write-back / EX handshake bundle for the decode stage.
// The slave side is the decode stage; the master side drives it.
interface id_stage_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) ();
  localparam int RW = $clog2(NREGS);

  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            flush;
  logic            wb_we;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_r1;
  logic [XLEN-1:0] ex_r2;
  logic [XLEN-1:0] ex_imm;
  logic [RW-1:0]   ex_rd;
  logic [10:0]     ex_ctrl;
  logic            ex_f7b5;
  logic            ex_illegal;

  modport master (
    output if_valid, if_instr, if_pc, flush,
    output wb_we, wb_rd, wb_data, ex_ready,
    input  if_ready, ex_valid, ex_pc, ex_r1, ex_r2,
    input  ex_imm, ex_rd, ex_ctrl, ex_f7b5, ex_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush,
    input  wb_we, wb_rd, wb_data, ex_ready,
    output if_ready, ex_valid, ex_pc, ex_r1, ex_r2,
    output ex_imm, ex_rd, ex_ctrl, ex_f7b5, ex_illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32 decode stage: register file, decoder, immediate generator,
// ID/EX register with valid/ready handshake and load-use stall.
module id_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  localparam int RW = $clog2(NREGS);

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic [2:0] funct3;
  } ctrl_t;

  logic [XLEN-1:0] rf [NREGS];

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;

  assign instr = bus.if_instr;
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  ctrl_t       ctrl, ctrl_d;
  logic [31:0] imm32;
  logic        has_rd, use1, use2, bad_op;

  always_comb begin
    ctrl   = '0;
    imm32  = '0;
    has_rd = 1'b0;
    use1   = 1'b0;
    use2   = 1'b0;
    bad_op = 1'b0;
    unique case (1'b1)
      opc == OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = 2'b10;
        has_rd = 1'b1;
        use1   = 1'b1;
        use2   = 1'b1;
      end
      opc == OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = 2'b10;
        imm32  = imm_i;
        has_rd = 1'b1;
        use1   = 1'b1;
      end
      opc == OP_LD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        imm32  = imm_i;
        has_rd = 1'b1;
        use1   = 1'b1;
      end
      opc == OP_ST: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm32 = imm_s;
        use1  = 1'b1;
        use2  = 1'b1;
      end
      opc == OP_BR: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = 2'b01;
        imm32 = imm_b;
        use1  = 1'b1;
        use2  = 1'b1;
      end
      opc == OP_LUI || opc == OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm32  = imm_u;
        has_rd = 1'b1;
      end
      opc == OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm32  = imm_j;
        has_rd = 1'b1;
      end
      opc == OP_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm32  = imm_i;
        has_rd = 1'b1;
        use1   = 1'b1;
      end
      default: bad_op = 1'b1;
    endcase
    ctrl.funct3 = bad_op ? 3'b0 : instr[14:12];
  end

  // Indices beyond the architectural file (RV32E) are illegal.
  logic rd_oob, rs1_oob, rs2_oob, illegal;

  assign rd_oob  = {1'b0, rd}  >= 6'(NREGS);
  assign rs1_oob = {1'b0, rs1} >= 6'(NREGS);
  assign rs2_oob = {1'b0, rs2} >= 6'(NREGS);
  assign illegal = bad_op | (has_rd & rd_oob) |
                   (use1 & rs1_oob) | (use2 & rs2_oob);
  assign ctrl_d  = illegal ? '0 : ctrl;

  logic            byp;
  logic [XLEN-1:0] r1, r2;

  assign byp = (BYPASS != 0) && bus.wb_we;

  always_comb begin
    r1 = '0;
    r2 = '0;
    if (rs1 != '0 && !rs1_oob)
      r1 = (byp && 5'(bus.wb_rd) == rs1) ?
           bus.wb_data : rf[rs1[RW-1:0]];
    if (rs2 != '0 && !rs2_oob)
      r2 = (byp && 5'(bus.wb_rd) == rs2) ?
           bus.wb_data : rf[rs2[RW-1:0]];
  end

  logic            v_q, f7_q, ill_q;
  logic [XLEN-1:0] pc_q, r1_q, r2_q, imm_q;
  logic [RW-1:0]   rd_q;
  ctrl_t           ctrl_q;
  logic            adv, haz;

  assign adv = !v_q || bus.ex_ready;
  assign haz = v_q && ctrl_q.mem_read && rd_q != '0 &&
               ((use1 && 5'(rd_q) == rs1) ||
                (use2 && 5'(rd_q) == rs2));

  assign bus.if_ready   = !rst && adv && !haz;
  assign bus.ex_valid   = v_q;
  assign bus.ex_pc      = pc_q;
  assign bus.ex_r1      = r1_q;
  assign bus.ex_r2      = r2_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_ctrl    = ctrl_q;
  assign bus.ex_f7b5    = f7_q;
  assign bus.ex_illegal = ill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      v_q    <= 1'b0;
      pc_q   <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      imm_q  <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
      f7_q   <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      if (bus.wb_we && bus.wb_rd != '0)
        rf[bus.wb_rd] <= bus.wb_data;
      if (bus.flush) begin
        v_q <= 1'b0;
      end else if (adv) begin
        if (haz || !bus.if_valid) begin
          v_q <= 1'b0;
        end else begin
          v_q    <= 1'b1;
          pc_q   <= bus.if_pc;
          r1_q   <= r1;
          r2_q   <= r2;
          imm_q  <= illegal ? '0 : XLEN'($signed(imm32));
          rd_q   <= (has_rd && !illegal) ? rd[RW-1:0] : '0;
          ctrl_q <= ctrl_d;
          f7_q   <= instr[30];
          ill_q  <= illegal;
        end
      end
    end
  end
endmodule
